fifo_write_arbiter: RTL and testbench
=====================================

// Module: fifo_write_arbiter
// PURPOSE
//  Shares the single write port of one fifo between num_req requesters.
//  Round-robin arbitration with burst locking: a winner keeps the port for up to max_burst words, then priority rotates.
//  Sits between producer blocks and a fifo instance; drives its write_data/write_enable and observes its full flag.
//  Transfer is zero-latency: the granted word is written into the fifo in the same cycle as its handshake.
// PARAMETERS
//  data_width  32  width of each requester word and of fifo_write_data
//  num_req     4   number of requesters, >= 2
//  max_burst   4   max consecutive words per grant, >= 1; 1 = pure per-word round-robin
// PORTS
//  clk                in   1                   clock, all state on rising edge
//  reset_n            in   1                   asynchronous active-low reset
//  req_valid          in   num_req             requester i has a word on its slice of req_data
//  req_data           in   num_req*data_width  requester i word at [i*data_width +: data_width]
//  req_ready          out  num_req             word i transfers this cycle when req_valid[i] & req_ready[i]
//  fifo_full          in   1                   full flag of the downstream fifo
//  fifo_write_data    out  data_width          selected requester word
//  fifo_write_enable  out  1                   write strobe to the fifo, = |(req_valid & req_ready)
//  grant_index        out  $clog2(num_req)     index of the selected requester; meaningful when fifo_write_enable=1
//  locked             out  1                   1 while in LOCKED state
// BEHAVIOUR
//  - State: st in {IDLE, LOCKED}, rr_ptr ($clog2(num_req) bits), owner ($clog2(num_req) bits),
//    burst_cnt ($clog2(max_burst+1) bits).
//  - Reset (async): st=IDLE, rr_ptr=0, owner=0, burst_cnt=0. While reset_n=0, req_ready=0 and fifo_write_enable=0.
//  - IDLE: winner = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod num_req.
//    req_ready[winner] = !fifo_full; all others 0. No valid requester -> no ready, state unchanged.
//  - IDLE, transfer occurs:
//    max_burst==1 -> stay IDLE, rr_ptr <= winner+1 mod num_req.
//    max_burst>1  -> st <= LOCKED, owner <= winner, burst_cnt <= 1.
//  - LOCKED: req_ready[owner] = !fifo_full; all others 0. Other requesters cannot preempt.
//    transfer and burst_cnt+1 == max_burst -> st <= IDLE, rr_ptr <= owner+1, burst_cnt <= 0.
//    transfer otherwise -> burst_cnt <= burst_cnt+1.
//    !req_valid[owner] -> st <= IDLE, rr_ptr <= owner+1, burst_cnt <= 0 (burst abandoned, no transfer).
//    req_valid[owner] & fifo_full -> stall; hold st, owner and burst_cnt.
//  - fifo_full=1 never produces a write; a stalled word is not lost, because the requester holds valid and data.
//  - Requesters must keep req_valid/req_data stable until accepted (valid/ready rule); arbiter does not check.
//  - Wrap: rr_ptr and owner+1 wrap modulo num_req. Non-power-of-two num_req must wrap (num_req-1) -> 0.
//  - grant_index = owner in LOCKED, winner in IDLE. fifo_write_data = req_data slice of grant_index.
//  - Outputs are combinational from state + inputs. No combinational path from fifo_full to req_valid.
//  - Reset mid-burst: immediate return to reset state; the next grant starts from requester 0.
// CONFIGURATION
//  FIFO_ARB_STATS_EN defined:
//    adds output grant_count  num_req*16, slice i at [i*16 +: 16].
//    Counts accepted words per requester; saturates at 16'hffff; async reset to 0.
//    Adds input  stats_clear  1, sync clear of all counters; a clear takes priority over a same-cycle increment.
//  FIFO_ARB_STATS_EN undefined: neither port exists, no counter logic; all other behaviour identical.
// TESTING
//  1. All 4 valid, fifo never full, max_burst=4: grants 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0 on consecutive cycles.
//  2. Only req 2 valid, with 3 words then valid drops: 3 writes in 3 cycles; next idle cycle leaves rr_ptr=3;
//     req 0 and req 3 then both valid -> req 3 granted first.
//  3. Req 1 locked after 2 words, fifo_full=1 for 5 cycles: no write, req_ready=0 for all, locked=1;
//     after full drops: exactly 2 more req 1 words, then rotation to the next requester.
//  4. max_burst=1, num_req=3, all valid: grants 0,1,2,0,1,2; locked stays 0.
//  5. reset_n low mid-burst (owner 2, burst_cnt 2): locked=0 and req_ready=0 at once;
//     after release, the first grant goes to the lowest valid index from 0.
//  6. FIFO_ARB_STATS_EN: 70000 req 0 writes -> grant_count[15:0]=16'hffff;
//     stats_clear for 1 cycle -> all slices 0 in the next cycle.

Source files
------------

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin write-port arbiter with burst locking; optional per-requester stats via FIFO_ARB_STATS_EN
module fifo_write_arbiter #(
    parameter int data_width = 32,
    parameter int num_req    = 4,
    parameter int max_burst  = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [num_req-1:0]            req_valid,
    input  logic [num_req*data_width-1:0] req_data,
    output logic [num_req-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic [data_width-1:0]         fifo_write_data,
    output logic                          fifo_write_enable,
    output logic [$clog2(num_req)-1:0]    grant_index,
    output logic                          locked
`ifdef FIFO_ARB_STATS_EN
    ,
    input  logic                          stats_clear,
    output logic [num_req*16-1:0]         grant_count
`endif
);
    localparam int IW = $clog2(num_req);
    localparam int BW = $clog2(max_burst + 1);

    typedef enum logic {IDLE, LOCKED} st_e;

    st_e           st_q;
    logic [IW-1:0] rr_q, owner_q, win, nxt_d, j_v;
    logic [BW-1:0] cnt_q;
    logic          found, any;
    int            j;

    function automatic logic [IW-1:0] inc(input logic [IW-1:0] x);
        return (int'(x) == num_req - 1) ? '0 : x + 1'b1;
    endfunction

    assign locked = (st_q == LOCKED);
    assign nxt_d  = inc(grant_index);

    // first valid requester searching upward from rr_q, wrapping at num_req
    always_comb begin
        win   = rr_q;
        found = 1'b0;
        j     = 0;
        j_v   = '0;
        for (int k = 0; k < num_req; k++) begin
            j = int'(rr_q) + k;
            if (j >= num_req) j = j - num_req;
            j_v = IW'(j);
            if (!found && req_valid[j_v]) begin
                win   = j_v;
                found = 1'b1;
            end
        end
    end

    // grant selection, ready decode and write-data mux
    always_comb begin
        grant_index     = locked ? owner_q : win;
        any             = locked ? req_valid[owner_q] : found;
        req_ready       = '0;
        fifo_write_data = '0;
        for (int i = 0; i < num_req; i++) begin
            req_ready[i] = reset_n && any && !fifo_full && (IW'(i) == grant_index);
            if (IW'(i) == grant_index) fifo_write_data = req_data[i*data_width +: data_width];
        end
        fifo_write_enable = |(req_valid & req_ready);
    end

    // arbitration FSM: IDLE picks a winner, LOCKED holds it until burst ends or it drops valid
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_q    <= IDLE;
            rr_q    <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
        end else if (st_q == IDLE) begin
            if (fifo_write_enable) begin
                if (max_burst == 1) rr_q <= nxt_d;
                else begin
                    st_q    <= LOCKED;
                    owner_q <= win;
                    cnt_q   <= BW'(1);
                end
            end
        end else if (!req_valid[owner_q] || (fifo_write_enable && int'(cnt_q) + 1 == max_burst)) begin
            st_q  <= IDLE;
            rr_q  <= nxt_d;
            cnt_q <= '0;
        end else if (fifo_write_enable) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

`ifdef FIFO_ARB_STATS_EN
    logic [15:0] gc_q [num_req];

    // saturating accepted-word counters; clear wins over a same-cycle increment
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < num_req; i++) gc_q[i] <= '0;
        end else begin
            for (int i = 0; i < num_req; i++)
                if (stats_clear) gc_q[i] <= '0;
                else if (req_valid[i] && req_ready[i] && gc_q[i] != 16'hffff) gc_q[i] <= gc_q[i] + 16'd1;
        end
    end

    // flatten counters onto the output bus
    always_comb begin
        grant_count = '0;
        for (int i = 0; i < num_req; i++) grant_count[i*16 +: 16] = gc_q[i];
    end
`endif
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: scoreboard bench for fifo_write_arbiter (4 req/burst 4 and 3 req/burst 1)
module tb_fifo_write_arbiter;
    typedef struct {int idx; logic [31:0] d;} ex_t;

    logic clk = 0, rst_n = 0;
    always #5 clk = ~clk;

    logic [3:0]   va = 0, ra;
    logic [127:0] da;
    logic         fa = 0, wea, la;
    logic [31:0]  wda;
    logic [1:0]   ga;
    logic [2:0]   vb = 0, rb;
    logic [95:0]  db;
    logic         fb = 0, web, lb;
    logic [31:0]  wdb;
    logic [1:0]   gb;
`ifdef FIFO_ARB_STATS_EN
    logic         clr = 0;
    logic [63:0]  gca;
    logic [47:0]  gcb;
`endif

    int  n_cmp = 0, n_err = 0;
    ex_t qa[$], qb[$];

    fifo_write_arbiter #(.data_width(32), .num_req(4), .max_burst(4)) u_a (
        .clk(clk), .reset_n(rst_n), .req_valid(va), .req_data(da), .req_ready(ra),
        .fifo_full(fa), .fifo_write_data(wda), .fifo_write_enable(wea),
        .grant_index(ga), .locked(la)
`ifdef FIFO_ARB_STATS_EN
        , .stats_clear(clr), .grant_count(gca)
`endif
    );

    fifo_write_arbiter #(.data_width(32), .num_req(3), .max_burst(1)) u_b (
        .clk(clk), .reset_n(rst_n), .req_valid(vb), .req_data(db), .req_ready(rb),
        .fifo_full(fb), .fifo_write_data(wdb), .fifo_write_enable(web),
        .grant_index(gb), .locked(lb)
`ifdef FIFO_ARB_STATS_EN
        , .stats_clear(clr), .grant_count(gcb)
`endif
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic pa(input int i);
        qa.push_back('{i, 32'hA000_0000 | i});
    endtask

    task automatic pb(input int i);
        qb.push_back('{i, 32'hB000_0000 | i});
    endtask

    // monitor for the 4-requester arbiter
    always @(negedge clk) begin
        ex_t e;
        if (wea) begin
            n_cmp++;
            if (qa.size() == 0) begin
                n_err++;
                $display("FAIL a_write: got unexpected grant %0d want no write", ga);
            end else begin
                e = qa.pop_front();
                if ({30'b0, ga} !== e.idx || wda !== e.d) begin
                    n_err++;
                    $display("FAIL a_write: got grant %0d data %h want grant %0d data %h", ga, wda, e.idx, e.d);
                end
            end
        end
    end

    // monitor for the 3-requester arbiter
    always @(negedge clk) begin
        ex_t e;
        if (web) begin
            n_cmp++;
            if (qb.size() == 0) begin
                n_err++;
                $display("FAIL b_write: got unexpected grant %0d want no write", gb);
            end else begin
                e = qb.pop_front();
                if ({30'b0, gb} !== e.idx || wdb !== e.d) begin
                    n_err++;
                    $display("FAIL b_write: got grant %0d data %h want grant %0d data %h", gb, wdb, e.idx, e.d);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 4; i++) da[i*32 +: 32] = 32'hA000_0000 | i;
        for (int i = 0; i < 3; i++) db[i*32 +: 32] = 32'hB000_0000 | i;
        va = 4'hf;
        #1;
        chk("rst_ready", {60'b0, ra}, 64'h0);
        chk("rst_we", {63'b0, wea}, 64'h0);
        chk("rst_locked", {63'b0, la}, 64'h0);
        cyc();
        cyc();
        va = 4'h0;
        rst_n = 1;
        #3;
        chk("idle_locked", {63'b0, la}, 64'h0);
        chk("idle_we", {63'b0, wea}, 64'h0);
        cyc();
        // bursts of four rotating through all requesters
        va = 4'hf;
        for (int k = 0; k < 16; k++) pa(k / 4);
        pa(0);
        repeat (17) cyc();
        va = 4'h0;
        cyc();
        // lone requester 2 abandons its burst after three words
        va = 4'b0100;
        repeat (3) pa(2);
        repeat (3) cyc();
        va = 4'h0;
        cyc();
        va = 4'b1001;
        pa(3);
        #3;
        chk("rr_after_abandon", {62'b0, ga}, 64'd3);
        cyc();
        va = 4'h0;
        cyc();
        // requester 1 stalls by a full fifo mid-burst
        va = 4'b0010;
        pa(1);
        pa(1);
        repeat (2) cyc();
        fa = 1;
        va = 4'hf;
        for (int k = 0; k < 5; k++) begin
            #3;
            chk("stall_locked", {63'b0, la}, 64'h1);
            chk("stall_ready", {60'b0, ra}, 64'h0);
            chk("stall_we", {63'b0, wea}, 64'h0);
            cyc();
        end
        fa = 0;
        pa(1);
        pa(1);
        pa(2);
        repeat (3) cyc();
        pa(2);
        cyc();
        // reset in the middle of owner 2's burst
        rst_n = 0;
        #1;
        chk("midrst_locked", {63'b0, la}, 64'h0);
        chk("midrst_ready", {60'b0, ra}, 64'h0);
        chk("midrst_we", {63'b0, wea}, 64'h0);
        cyc();
        cyc();
        va = 4'b1110;
        rst_n = 1;
        pa(1);
        #3;
        chk("post_rst_grant", {62'b0, ga}, 64'd1);
        cyc();
        va = 4'h0;
        cyc();
        // per-word round-robin with three requesters
        vb = 3'b111;
        for (int k = 0; k < 6; k++) pb(k % 3);
        for (int k = 0; k < 6; k++) begin
            #3;
            chk("b_locked", {63'b0, lb}, 64'h0);
            cyc();
        end
        fb = 1;
        #3;
        chk("b_full_we", {63'b0, web}, 64'h0);
        chk("b_full_ready", {61'b0, rb}, 64'h0);
        cyc();
        fb = 0;
        vb = 3'b000;
        cyc();
`ifdef FIFO_ARB_STATS_EN
        va = 4'b0001;
        for (int k = 0; k < 70000; k++) begin
            pa(0);
            cyc();
        end
        chk("gc_saturate", {48'b0, gca[15:0]}, 64'hffff);
        chk("gc_other", {16'b0, gca[63:16]}, 64'h0);
        clr = 1;
        pa(0);
        cyc();
        clr = 0;
        va = 4'h0;
        chk("gc_clear_a", gca, 64'h0);
        chk("gc_clear_b", {16'b0, gcb}, 64'h0);
        cyc();
`endif
        repeat (2) cyc();
        n_cmp++;
        if (qa.size() + qb.size() != 0) begin
            n_err++;
            $display("FAIL pending_writes: got %0d outstanding want 0", qa.size() + qb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
